// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle controller: FSM states, opcodes,
// funcodes, ALU operations and datapath mux selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // Also consumed by alu_32bit
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRC_B_RT     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: decoded instruction fields and
// status in, mux selects and strobes out.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;

    // zero only qualifies pc_write_cond inside the datapath
    modport master (
        input  opcode, funcode, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op
    );

    modport slave (
        output opcode, funcode, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op
    );
endinterface

// File: rtl/mips_alu_decode.sv
// R-type funcode to ALU operation map with a legality flag; shared with the
// single-cycle control path.
module mips_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funcode,
    output logic [2:0] alu_op,
    output logic       legal
);
    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funcode)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore multicycle sequencer for the MIPS core: per-instruction FSM driving the
// shared datapath and unified memory port, plus a retired-instruction counter.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    mips_multicycle_ctrl_if.master bus,
    output logic [3:0]           state,
    output logic                 illegal,
    output logic [CNT_W-1:0]     retired
);
    state_t     cur;
    state_t     dec_next;
    logic [2:0] r_alu_op;
    logic       funct_ok;
    logic       op_legal;
    logic       retire;

    mips_alu_decode u_alu_decode (
        .funcode (bus.funcode),
        .alu_op  (r_alu_op),
        .legal   (funct_ok)
    );

    always_comb begin
        op_legal = 1'b1;
        dec_next = S_FETCH;
        case (bus.opcode)
            OP_LW, OP_SW: dec_next = S_MEM_ADDR;
            OP_RTYPE: begin
                dec_next = S_EXEC_R;
                op_legal = funct_ok;
            end
            OP_ADDI:  dec_next = S_EXEC_I;
            OP_BEQ:   dec_next = S_BRANCH;
            OP_J:     dec_next = S_JUMP;
            default:  op_legal = 1'b0;
        endcase
    end

    assign retire = (cur inside {S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP}) ||
                    (cur == S_MEM_WR && bus.mem_ready);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur     <= S_FETCH;
            retired <= '0;
        end else begin
            if (retire) retired <= retired + CNT_W'(1);
            case (cur)
                S_FETCH:    if (bus.mem_ready) cur <= S_DECODE;
                S_DECODE:   cur <= op_legal ? dec_next : S_FETCH;
                S_MEM_ADDR: cur <= (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD:   if (bus.mem_ready) cur <= S_MEM_WB;
                S_MEM_WR:   if (bus.mem_ready) cur <= S_FETCH;
                S_EXEC_R:   cur <= S_WB_R;
                S_EXEC_I:   cur <= S_WB_I;
                default:    cur <= S_FETCH;
            endcase
        end
    end

    assign state = cur;

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = PC_SRC_ALU;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRC_B_RT;
        bus.alu_op        = ALU_AND;
        illegal           = 1'b0;
        case (cur)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRC_B_FOUR;
                bus.alu_op    = ALU_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b = SRC_B_IMM_SH;
                bus.alu_op    = ALU_ADD;
                illegal       = !op_legal;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRC_B_IMM;
                bus.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                bus.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = r_alu_op;
            end
            S_WB_R: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_WB_I: bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PC_SRC_JUMP;
            end
            default: ;
        endcase
        // Asynchronous reset must kill strobes at once, even mid-cycle
        if (!reset) begin
            bus.pc_write      = 1'b0;
            bus.pc_write_cond = 1'b0;
            bus.ir_write      = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.reg_write     = 1'b0;
            illegal           = 1'b0;
        end
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style multicycle sequencer for the MIPS core. It replaces single-cycle control with a per-instruction state machine that drives the shared PC, instruction register, register file, ALU muxes and one unified memory port. It decodes the opcode and funcode into ALU operations, stalls on a memory ready handshake, and counts retired instructions. It sits between the instruction/data memory interface and the existing datapath units: program counter, register file, extender, ALU and 2:1 muxes.

## Interface

**Parameters**
- CNT_W, 32: width of the retired-instruction counter.

**Ports**
- `clock`, input, 1: single clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low.
- `opcode`, input, 6: instruction[31:26], taken from the instruction register.
- `funcode`, input, 6: instruction[5:0].
- `zero`, input, 1: ALU zero flag.
- `mem_ready`, input, 1: memory has completed the current access this cycle.
- `pc_write`, output, 1: unconditional PC load.
- `pc_write_cond`, output, 1: PC load qualified by `zero` (beq).
- `pc_source`, output, 2: PC mux select. 00 = ALU result, 01 = ALUOut register, 10 = jump target.
- `i_or_d`, output, 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_read`, output, 1: read strobe.
- `mem_write`, output, 1: write strobe.
- `ir_write`, output, 1: instruction register load.
- `reg_dst`, output, 1: write register select. 0 = rt, 1 = rd.
- `mem_to_reg`, output, 1: write-back select. 0 = ALUOut, 1 = MDR.
- `reg_write`, output, 1: register file write enable.
- `alu_src_a`, output, 1: ALU A select. 0 = PC, 1 = rs data.
- `alu_src_b`, output, 2: ALU B select. 00 = rt data, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op`, output, 3: ALU operation. 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `state`, output, 4: current state, for debug.
- `illegal`, output, 1: one-cycle pulse in DECODE when the opcode or funcode is unsupported.
- `retired`, output, CNT_W: count of completed instructions.

## Operation

**States:** FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP.

**FETCH**
- Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=010, pc_source=00.
- ir_write and pc_write equal `mem_ready`.
- Stays in FETCH while `mem_ready`=0. Goes to DECODE on `mem_ready`=1.

**DECODE**
- Computes the branch target: alu_src_a=0, alu_src_b=11, alu_op=010.
- Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEM_ADDR.
  - 000000 (R-type) → EXEC_R.
  - 001000 (addi) → EXEC_I.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - Anything else → pulse `illegal` and go to FETCH. Not counted as retired.
- R-type with a funcode outside {100000, 100010, 100100, 100101, 101010} → same handling as an illegal opcode.

**Execute and memory states**
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, i_or_d=1. Waits for `mem_ready`, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Retires, goes to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits for `mem_ready`, then retires and goes to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00. alu_op from funcode: add→010, sub→110, and→000, or→001, slt→111. Goes to WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0. Retires, goes to FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=010. Goes to WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0. Retires, goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_write_cond=1, pc_source=01. Retires, goes to FETCH.
- JUMP: pc_write=1, pc_source=10. Retires, goes to FETCH.

**Defaults and counter**
- Any output not listed for a state is 0.
- "Retires" means `retired` increments by 1 on that clock edge.
- `retired` wraps modulo 2^CNT_W.

## Timing

**Reset**
- While `reset`=0: state=FETCH, retired=0, and all strobes are forced to 0 (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write).
- While `reset`=0, muxes and `alu_op` hold their FETCH values. `illegal`=0.
- Reset asserted mid-instruction aborts immediately. No partial write-back occurs after the asynchronous edge.
- First FETCH strobes appear in the cycle after `reset` is released.

**Latency with mem_ready tied to 1**
- beq: 3 cycles. j: 3 cycles.
- R-type, addi and sw: 4 cycles each.
- lw: 5 cycles.
- Each cycle with `mem_ready`=0 in FETCH, MEM_RD or MEM_WR adds one cycle.

**Handshake and output timing**
- Strobes are held constant while waiting on `mem_ready`.
- `mem_ready` is ignored in all other states.
- Outputs are combinational from `state`. Only ir_write and pc_write in FETCH also depend on `mem_ready`.

## Structure

- Shared package `mips_ctrl_pkg` holds:
  - the state encoding (4-bit localparams);
  - the opcode constants;
  - the funcode constants;
  - the ALU op constants;
  - the `alu_src_b` and `pc_source` encodings.
- The ALU op constants are shared with `alu_32bit`.
- One sub-module, `mips_alu_decode`: a combinational funcode→`alu_op` map plus funcode-legal flag, reusable by the single-cycle path.
- The FSM and the counter live in the top module.

## Test plan

- Reset release, opcode=000000, funcode=100000, mem_ready=1: states FETCH→DECODE→EXEC_R→WB_R. reg_write=1 and reg_dst=1 in cycle 4. retired=1 after 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in MEM_RD: mem_read and i_or_d=1 held for 3 cycles. Total 7 cycles. mem_to_reg=1 in MEM_WB.
- beq (000100): BRANCH drives alu_op=110, pc_write_cond=1, pc_source=01. Back to FETCH after 3 cycles.
- j (000010) followed by sw (101011): pc_write=1, pc_source=10 in cycle 3. sw asserts mem_write exactly once with mem_ready=1. retired=2 after 7 cycles.
- Illegal opcode 111111, then R-type with funcode 000111: `illegal` pulses in DECODE each time, returns to FETCH, retired unchanged. A FETCH stall with mem_ready=0 keeps ir_write=0.
- Reset asserted during MEM_WR: mem_write drops asynchronously, state=FETCH, retired=0. Also check wrap: preload retired=2^CNT_W−1, then a retire gives 0.
